// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transfer sequencer: FSM encoding and its width.
package spi_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_STORE     = 3'd4
  } state_t;

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; push is refused when full, pop when empty.
module spi_sync_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [DATA_WIDTH-1:0]         din,
  input  logic                          pop,
  output logic [DATA_WIDTH-1:0]         dout,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [LW-1:0]         count;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == LW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign level   = count;
  // Head word is forced to zero when empty so the output never shows stale storage.
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/spi_xfer_sequencer.sv
// Moves words from a host TX FIFO through an SPI master one at a time and
// collects the returned words into a host RX FIFO, with a master timeout.
//
//   state     | meaning
//   IDLE      | waiting for enable, TX word, RX space, master idle, no error
//   LAUNCH    | m_start_tx pulsed, m_tx_data holds the popped word
//   WAIT_BUSY | waiting for master to report busy (or finish outright)
//   WAIT_DONE | master busy, waiting for m_irq
//   STORE     | captured reply pushed into RX FIFO
module spi_xfer_sequencer
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          clr_err,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic [DATA_WIDTH-1:0]         tx_word,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [DATA_WIDTH-1:0]         rx_word,
  output logic                          m_start_tx,
  output logic [DATA_WIDTH-1:0]         m_tx_data,
  input  logic                          m_busy,
  input  logic                          m_irq,
  input  logic [DATA_WIDTH-1:0]         m_rx_data,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  output logic                          active,
  output logic                          err_timeout
);

  // Counter can hold TIMEOUT_CYCLES so a busy seen on the last cycle still times out in WAIT_DONE.
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TC = CW'(TIMEOUT_CYCLES - 1);

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] tx_head;
  logic [DATA_WIDTH-1:0] rx_cap;
  logic                  tx_full, tx_empty, rx_full, rx_empty;
  logic                  launch_ok, tx_pop, rx_push;

  assign launch_ok = enable && !tx_empty && !rx_full && !m_busy && !err_timeout;
  assign tx_pop    = (state == S_IDLE) && launch_ok;
  assign rx_push   = (state == S_STORE);
  assign tx_ready  = !tx_full;
  assign rx_valid  = !rx_empty;
  assign active    = (state != S_IDLE);

  spi_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_valid), .din(tx_word), .pop(tx_pop),
    .dout(tx_head), .full(tx_full), .empty(tx_empty), .level(tx_level)
  );

  spi_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .din(rx_cap), .pop(rx_ready),
    .dout(rx_word), .full(rx_full), .empty(rx_empty), .level(rx_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      m_start_tx  <= 1'b0;
      m_tx_data   <= '0;
      rx_cap      <= '0;
      err_timeout <= 1'b0;
    end else begin
      m_start_tx <= 1'b0;
      if (clr_err) err_timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (launch_ok) begin
            m_tx_data  <= tx_head;
            m_start_tx <= 1'b1;
            state      <= S_LAUNCH;
          end
        end
        S_LAUNCH: state <= S_WAIT_BUSY;
        S_WAIT_BUSY, S_WAIT_DONE: begin
          cnt <= cnt + CW'(1);
          if (m_irq) begin
            rx_cap <= m_rx_data;
            cnt    <= '0;
            state  <= S_STORE;
          end else if (state == S_WAIT_BUSY && m_busy) begin
            state <= S_WAIT_DONE;
          end else if (cnt >= TC) begin
            // Timeout set is written after the clear so it wins in a shared cycle.
            err_timeout <= 1'b1;
            cnt         <= '0;
            state       <= S_IDLE;
          end
        end
        S_STORE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Directed bench for spi_xfer_sequencer with a behavioural SPI master model.
module tb_spi_xfer_sequencer;

  localparam int DW = 16;
  localparam int DEPTH = 16;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst, enable, clr_err, tx_valid, rx_ready;
  logic [DW-1:0] tx_word;
  logic tx_ready, rx_valid, m_start_tx, active, err_timeout;
  logic [DW-1:0] rx_word, m_tx_data;
  logic m_busy, m_irq;
  logic [DW-1:0] m_rx_data;
  logic [$clog2(DEPTH):0] tx_level, rx_level;

  int total = 0;
  int bad = 0;
  int start_cnt = 0;
  int mode = 0;          // 0 echo inverted, 1 silent, 2 hold busy until release
  logic hold_release = 1'b0;

  spi_xfer_sequencer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .enable(enable), .clr_err(clr_err),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_word(tx_word),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_word(rx_word),
    .m_start_tx(m_start_tx), .m_tx_data(m_tx_data), .m_busy(m_busy),
    .m_irq(m_irq), .m_rx_data(m_rx_data),
    .tx_level(tx_level), .rx_level(rx_level), .active(active), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (m_start_tx) start_cnt <= start_cnt + 1;

  initial begin
    m_busy = 1'b0; m_irq = 1'b0; m_rx_data = '0;
    forever begin
      @(posedge clk); #1;
      if (m_start_tx && mode == 0) begin
        m_busy = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        m_busy = 1'b0; m_irq = 1'b1; m_rx_data = ~m_tx_data;
        @(posedge clk); #1;
        m_irq = 1'b0;
      end else if (m_start_tx && mode == 2) begin
        m_busy = 1'b1;
        while (!hold_release) begin @(posedge clk); #1; end
        m_busy = 1'b0; m_irq = 1'b1; m_rx_data = 16'h5555;
        @(posedge clk); #1;
        m_irq = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic wait_rx(input int n, input int budget, input string tag);
    for (int k = 0; k < budget && rx_level != n; k++) tick();
    check(tag, 32'(rx_level), 32'(n));
  endtask

  task automatic push(input logic [DW-1:0] w);
    tx_valid = 1'b1; tx_word = w;
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [DW-1:0] exp_w);
    check(tag, 32'(rx_word), 32'(exp_w));
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  initial begin
    int s0;
    int got;
    rst = 1'b1; enable = 1'b0; clr_err = 1'b0; tx_valid = 1'b0; rx_ready = 1'b0; tx_word = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_active", 32'(active), 0);
    check("rst_tx_level", 32'(tx_level), 0);
    check("rst_rx_level", 32'(rx_level), 0);
    check("rst_tx_ready", 32'(tx_ready), 1);
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_err", 32'(err_timeout), 0);
    check("rst_start", 32'(m_start_tx), 0);
    check("rst_m_tx_data", 32'(m_tx_data), 0);
    check("rst_rx_word", 32'(rx_word), 0);

    // Three echoed transfers
    enable = 1'b1;
    push(16'h1234); push(16'hA5A5); push(16'h0F0F);
    wait_rx(3, 60, "echo_rx_level");
    check("echo_starts", 32'(start_cnt), 3);
    pop_check("echo_w0", 16'hEDCB);
    pop_check("echo_w1", 16'h5A5A);
    pop_check("echo_w2", 16'hF0F0);
    check("echo_empty", 32'(rx_valid), 0);

    // Fill TX with enable low, 17th push refused
    enable = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i == 15) check("tx_ready_at_15", 32'(tx_ready), 1);
      if (i == 16) check("tx_ready_at_16", 32'(tx_ready), 0);
      push(16'h0100 + 16'(i));
    end
    check("tx_full_level", 32'(tx_level), 16);
    check("tx_full_ready", 32'(tx_ready), 0);

    // Drain into RX until RX is full
    s0 = start_cnt;
    enable = 1'b1;
    wait_rx(16, 150, "rx_full_level");
    check("rx_full_starts", 32'(start_cnt - s0), 16);
    check("rx_full_tx_level", 32'(tx_level), 0);
    push(16'hBEEF);
    repeat (8) tick();
    check("rx_full_no_launch", 32'(active), 0);
    check("rx_full_tx_held", 32'(tx_level), 1);
    pop_check("rx_first", 16'hFEFF);
    got = 0;
    for (int k = 0; k < 2 && got == 0; k++) begin
      tick();
      if (active) got = 1;
    end
    check("launch_after_pop", 32'(got), 1);
    wait_rx(16, 20, "rx_refill");
    for (int i = 1; i < 16; i++) pop_check("rx_drain", ~(16'h0100 + 16'(i)));
    pop_check("rx_drain_last", 16'h4110);
    check("rx_drained", 32'(rx_level), 0);

    // Simultaneous TX push and launch pop at level 5; enable drop mid-transfer
    enable = 1'b0;
    for (int i = 0; i < 5; i++) push(16'h0200 + 16'(i));
    check("tx_level5", 32'(tx_level), 5);
    enable = 1'b1; tx_valid = 1'b1; tx_word = 16'h0205;
    tick();
    tx_valid = 1'b0; enable = 1'b0;
    check("pushpop_level", 32'(tx_level), 5);
    check("pushpop_head", 32'(m_tx_data), 16'h0200);
    check("pushpop_active", 32'(active), 1);
    repeat (10) tick();
    check("noabort_rx", 32'(rx_level), 1);
    check("noabort_tx", 32'(tx_level), 5);
    check("noabort_idle", 32'(active), 0);
    enable = 1'b1;
    wait_rx(6, 60, "order_rx_level");
    for (int i = 0; i < 6; i++) pop_check("order_word", ~(16'h0200 + 16'(i)));

    // Silent master -> timeout
    mode = 1;
    s0 = start_cnt;
    push(16'h0300);
    got = 0;
    for (int k = 0; k < 5 && got == 0; k++) begin
      tick();
      if (m_start_tx) got = 1;
    end
    check("tmo_start_seen", 32'(got), 1);
    tick();
    repeat (7) tick();
    check("tmo_not_yet", 32'(err_timeout), 0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("tmo_set_wins", 32'(err_timeout), 1);
    check("tmo_idle", 32'(active), 0);
    check("tmo_rx_level", 32'(rx_level), 0);
    push(16'h0301);
    repeat (6) tick();
    check("tmo_blocked", 32'(active), 0);
    check("tmo_blocked_starts", 32'(start_cnt - s0), 1);
    check("tmo_blocked_tx", 32'(tx_level), 1);
    mode = 0;
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("tmo_cleared", 32'(err_timeout), 0);
    wait_rx(1, 20, "tmo_resume");
    pop_check("tmo_resume_word", 16'hFCFE);

    // Reset during WAIT_DONE
    mode = 2;
    enable = 1'b0;
    push(16'h0400); push(16'h0401);
    enable = 1'b1;
    got = 0;
    for (int k = 0; k < 5 && got == 0; k++) begin
      tick();
      if (m_start_tx) got = 1;
    end
    check("rstmid_start_seen", 32'(got), 1);
    tick(); tick();
    check("rstmid_active_before", 32'(active), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_active", 32'(active), 0);
    check("rstmid_tx_level", 32'(tx_level), 0);
    check("rstmid_rx_level", 32'(rx_level), 0);
    check("rstmid_start", 32'(m_start_tx), 0);
    check("rstmid_m_tx_data", 32'(m_tx_data), 0);
    hold_release = 1'b1;
    repeat (6) tick();
    hold_release = 1'b0;
    check("rstmid_irq_ignored", 32'(rx_level), 0);
    check("rstmid_rx_valid", 32'(rx_valid), 0);
    check("rstmid_still_idle", 32'(active), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_xfer_sequencer.md
SPI_XFER_SEQUENCER -- requirements
Module: spi_xfer_sequencer

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, 16, word width; FIFO_DEPTH, 16, entries per FIFO (power of 2, >=2); TIMEOUT_CYCLES, 4096, max cycles waiting on master.
REQ-002 SHALL have ports: clk  in  1  single clock, all logic on rising edge; rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: enable  in  1  permits new transfer launches; clr_err  in  1  clears sticky error.
REQ-004 SHALL have host TX push ports: tx_valid in 1, tx_ready out 1, tx_word in DATA_WIDTH.
REQ-005 SHALL have host RX pop ports: rx_valid out 1, rx_ready in 1, rx_word out DATA_WIDTH.
REQ-006 SHALL have SPI master-side ports: m_start_tx out 1, m_tx_data out DATA_WIDTH, m_busy in 1, m_irq in 1, m_rx_data in DATA_WIDTH.
REQ-007 SHALL have status ports: tx_level out $clog2(FIFO_DEPTH)+1; rx_level out $clog2(FIFO_DEPTH)+1; active out 1; err_timeout out 1 (sticky).

Function
REQ-008 SHALL contain a TX FIFO and an RX FIFO, each FIFO_DEPTH words, first-word-fall-through.
REQ-009 Push SHALL occur when tx_valid && tx_ready; tx_ready = TX FIFO not full; pop RX when rx_valid && rx_ready; rx_valid = RX FIFO not empty.
REQ-010 Simultaneous push and pop on the same FIFO SHALL both complete, level unchanged, including when full (pop frees slot same cycle is NOT used: full blocks push) and when empty (push only).
REQ-011 Read/write pointers SHALL wrap modulo FIFO_DEPTH; level SHALL count 0..FIFO_DEPTH exactly.
REQ-012 FSM states SHALL be IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, STORE.
REQ-013 IDLE->LAUNCH SHALL occur when enable && TX FIFO non-empty && RX FIFO not full && !m_busy; otherwise remain IDLE.
REQ-014 On IDLE->LAUNCH the TX head word SHALL be popped and registered into m_tx_data, held stable until the FSM returns to IDLE.
REQ-015 In LAUNCH m_start_tx SHALL be 1 for exactly one cycle; next state WAIT_BUSY.
REQ-016 WAIT_BUSY->WAIT_DONE SHALL occur on first cycle m_busy=1; m_irq seen in WAIT_BUSY SHALL also go directly to STORE.
REQ-017 WAIT_DONE->STORE SHALL occur on the cycle m_irq=1; m_rx_data SHALL be captured that cycle.
REQ-018 STORE SHALL push the captured word into the RX FIFO (space guaranteed by REQ-013) and go to IDLE next cycle; back-to-back transfer minimum gap is one IDLE cycle.
REQ-019 A cycle counter SHALL run in WAIT_BUSY and WAIT_DONE; on reaching TIMEOUT_CYCLES-1 without the exit condition, err_timeout SHALL set, the word SHALL be discarded (no RX push), FSM to IDLE.
REQ-020 While err_timeout=1 no new launch SHALL occur; clr_err=1 clears it next cycle; set and clear in the same cycle -> set wins.
REQ-021 active SHALL be 1 in every state except IDLE.
REQ-022 Deasserting enable mid-transfer SHALL NOT abort; the current word completes, no further launch.

Reset
REQ-023 On rst=1 at a clock edge: FSM=IDLE, both FIFOs empty, levels 0, m_start_tx=0, m_tx_data=0, rx_word undefined-free (0), rx_valid=0, tx_ready=1, active=0, err_timeout=0, counter=0.
REQ-024 Reset mid-transfer SHALL take effect in one cycle, discard in-flight and buffered words, and assert no m_start_tx in the reset cycle.

Structure
REQ-025 FSM state encoding and FSM width constant SHALL reside in shared package spi_pkg.
REQ-026 Both FIFOs SHALL be instances of one sub-module spi_sync_fifo (DATA_WIDTH, FIFO_DEPTH params, push/pop/full/empty/level).

Verification
REQ-027 Push 0x1234, 0xA5A5, 0x0F0F with enable=1, model master echoing inverted data -> three m_start_tx pulses, RX pops 0xEDCB, 0x5A5A, 0xF0F0 in order.
REQ-028 Push 17 words with enable=0 (DEPTH 16) -> tx_ready=0 after 16th, 17th not accepted, tx_level=16.
REQ-029 RX FIFO filled to 16 with host rx_ready=0 -> no launch while full; one pop -> launch within 2 cycles.
REQ-030 Master never asserts m_busy, TIMEOUT_CYCLES=8 -> err_timeout=1 exactly 8 cycles after entering WAIT_BUSY, rx_level unchanged; clr_err -> resumes.
REQ-031 Assert rst during WAIT_DONE -> next cycle active=0, levels 0, m_start_tx=0; later m_irq ignored.
REQ-032 Simultaneous push and pop on TX FIFO at level 5 -> level stays 5, order preserved.
